// File: rtl/decode_pkg.sv
// Shared types and constants for the MIPS decode stage: format codes, opcodes,
// handshake state encoding and the decoded bundle carried through the stage.
package decode_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_ILL = 2'd3
    } fmt_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Wide fields sized for the largest XLEN/PC_W; the top truncates on output.
    typedef struct packed {
        logic [5:0]       opcode;
        logic [4:0]       rs;
        logic [4:0]       rt;
        logic [4:0]       rd;
        logic [4:0]       shamt;
        logic [5:0]       funct;
        fmt_e             fmt;
        logic [MAX_W-1:0] imm_ext;
        logic [MAX_W-1:0] target;
        logic [MAX_W-1:0] pc;
    } bundle_t;

    function automatic fmt_e decode_fmt(input logic [5:0] op);
        case (op)
            OP_SPECIAL:                                    return FMT_R;
            OP_J, OP_JAL:                                  return FMT_J;
            OP_REGIMM, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0B,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:                           return FMT_I;
            default:                                       return FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational MIPS field decode: slices fields, classifies the format
// and computes the extended immediate and branch/jump target.
module instr_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output bundle_t         bundle
);

    logic [5:0]      op;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc4;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_x;
    logic [XLEN-1:0] tgt_x;
    fmt_e            fmt;

    assign op  = instr[31:26];
    assign imm = instr[15:0];

    always_comb begin
        pc4    = pc + PC_W'(4);
        imm_sx = XLEN'($signed(imm));
        fmt    = decode_fmt(op);

        imm_x = imm_sx;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: imm_x = XLEN'(imm);
            OP_LUI:                   imm_x = XLEN'($signed({imm, 16'h0000}));
            default:                  imm_x = imm_sx;
        endcase

        // Branch offsets are always sign-extended words, even for logical-immediate opcodes.
        if (fmt == FMT_J)
            tgt_x = XLEN'({pc4[PC_W-1:28], instr[25:0], 2'b00});
        else
            tgt_x = XLEN'(pc4) + (imm_sx << 2);

        bundle.opcode  = op;
        bundle.rs      = instr[25:21];
        bundle.rt      = instr[20:16];
        bundle.rd      = instr[15:11];
        bundle.shamt   = instr[10:6];
        bundle.funct   = instr[5:0];
        bundle.fmt     = fmt;
        bundle.imm_ext = MAX_W'(imm_x);
        bundle.target  = MAX_W'(tgt_x);
        bundle.pc      = MAX_W'(pc);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes before the register and holds bundles behind a
// valid/ready handshake, either as a two-entry skid buffer or a single register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [1:0]      out_fmt,
    output logic [XLEN-1:0] out_imm_ext,
    output logic [XLEN-1:0] out_target,
    output logic [PC_W-1:0] out_pc
);

    bundle_t dec_bundle;
    bundle_t out_reg;
    logic    accept;
    logic    fire;

    instr_decode #(.XLEN(XLEN), .PC_W(PC_W)) u_decode (
        .instr  (in_instr),
        .pc     (in_pc),
        .bundle (dec_bundle)
    );

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            state_e  state_reg, state_next;
            bundle_t skid_reg;
            logic    in_ready_reg;
            logic    load_out, out_from_skid, load_skid;

            always_comb begin
                state_next    = state_reg;
                load_out      = 1'b0;
                out_from_skid = 1'b0;
                load_skid     = 1'b0;
                case (state_reg)
                    ST_EMPTY: if (accept) begin
                        state_next = ST_ONE;
                        load_out   = 1'b1;
                    end
                    ST_ONE: begin
                        if (accept && fire) begin
                            load_out = 1'b1;
                        end else if (accept) begin
                            state_next = ST_TWO;
                            load_skid  = 1'b1;
                        end else if (fire) begin
                            state_next = ST_EMPTY;
                        end
                    end
                    ST_TWO: if (fire) begin
                        state_next    = ST_ONE;
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                    end
                    default: state_next = ST_EMPTY;
                endcase
                if (flush) begin
                    state_next = ST_EMPTY;
                    load_out   = 1'b0;
                    load_skid  = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= ST_EMPTY;
                    out_reg      <= '0;
                    skid_reg     <= '0;
                    in_ready_reg <= 1'b1;
                end else begin
                    state_reg    <= state_next;
                    in_ready_reg <= (state_next != ST_TWO);
                    if (load_out)
                        out_reg <= out_from_skid ? skid_reg : dec_bundle;
                    if (load_skid)
                        skid_reg <= dec_bundle;
                end
            end

            assign out_valid = (state_reg != ST_EMPTY);
            assign in_ready  = in_ready_reg & ~flush;
        end else begin : g_reg
            logic valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    out_reg   <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (accept) begin
                    valid_reg <= 1'b1;
                    out_reg   <= dec_bundle;
                end else if (fire) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid = valid_reg;
            assign in_ready  = (~valid_reg | out_ready) & ~flush;
        end
    endgenerate

    assign out_opcode  = out_reg.opcode;
    assign out_rs      = out_reg.rs;
    assign out_rt      = out_reg.rt;
    assign out_rd      = out_reg.rd;
    assign out_shamt   = out_reg.shamt;
    assign out_funct   = out_reg.funct;
    assign out_fmt     = out_reg.fmt;
    assign out_imm_ext = out_reg.imm_ext[XLEN-1:0];
    assign out_target  = out_reg.target[XLEN-1:0];
    assign out_pc      = out_reg.pc[PC_W-1:0];

    // Upper bits of the wide bundle fields are unused at narrower widths.
    logic unused_hi;
    assign unused_hi = ^{out_reg.imm_ext, out_reg.target, out_reg.pc};

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32: width of extended immediate and branch/jump targets; legal values 32 or 64.
REQ-002 Parameter PC_W, default 32: width of pc input; PC_W <= XLEN.
REQ-003 Parameter SKID, default 1: 1 gives a two-entry skid buffer (full throughput); 0 gives a single register where in_ready = !out_valid | out_ready.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in_valid  input  1  upstream instruction valid.
REQ-007 Port in_ready  output  1  stage can accept; when SKID=1, driven from a register.
REQ-008 Port in_instr  input  32  MIPS instruction word.
REQ-009 Port in_pc  input  PC_W  address of in_instr.
REQ-010 Port flush  input  1  discard all held and incoming instructions.
REQ-011 Port out_valid  output  1  decoded bundle valid.
REQ-012 Port out_ready  input  1  downstream accepts.
REQ-013 Ports out_opcode 6, out_rs 5, out_rt 5, out_rd 5, out_shamt 5, out_funct 6  output  instruction fields.
REQ-014 Port out_fmt  output  2  format: 0=R, 1=I, 2=J, 3=illegal.
REQ-015 Port out_imm_ext  output  XLEN  extended immediate.
REQ-016 Port out_target  output  XLEN  branch/jump target.
REQ-017 Port out_pc  output  PC_W  pc of the bundle.

Function
REQ-018 Field slicing: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0].
REQ-019 fmt: opcode 0x00 -> R; 0x02, 0x03 -> J; 0x01, 0x04-0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B -> I; any other -> illegal (bundle still emitted).
REQ-020 imm_ext: opcodes 0x0C, 0x0D, 0x0E zero-extend; 0x0F gives imm<<16, sign-extended to XLEN; all other opcodes sign-extend.
REQ-021 target: J fmt -> {pc4[PC_W-1:28], addr, 2'b00}, zero-extended to XLEN, where pc4 = in_pc+4; every other fmt -> pc4 + (sign-extended imm << 2), modulo 2^XLEN.
REQ-022 Latency: an instruction accepted (in_valid & in_ready) in cycle N appears on the outputs in cycle N+1.
REQ-023 Bundles leave in acceptance order; none is dropped or duplicated except by flush or rst.
REQ-024 Outputs hold stable while out_valid & !out_ready.
REQ-025 SKID=1 states: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), TWO (out_valid=1, in_ready=0; second entry in skid register).
REQ-026 EMPTY: accept -> ONE.
REQ-027 ONE: accept & out fire -> ONE with the new bundle; accept only -> TWO; out fire only -> EMPTY.
REQ-028 TWO: out fire -> ONE, skid entry moves to output; otherwise hold.
REQ-029 flush: next state EMPTY and all held bundles discarded; an input presented in the same cycle is not accepted (in_ready is forced low combinationally that cycle); flush takes priority over out_ready.
REQ-030 Decode is performed before the register, so held bundles are fully decoded.

Reset
REQ-031 While rst is high at a clock edge: state=EMPTY, out_valid=0, and all data outputs and the skid register are cleared to 0.
REQ-032 in_ready is 1 in the first cycle after rst deasserts; rst overrides flush and any handshake.

Structure
REQ-033 Shared package decode_pkg holds: the fmt encodings, the opcode constants, the state enum, and the bundle struct (fields, fmt, imm_ext, target, pc).
REQ-034 Combinational sub-module instr_decode (parametrised by XLEN and PC_W) computes the bundle from in_instr and in_pc; decode_stage holds the handshake and storage.

Verification
REQ-035 0x2008FFFF at pc 0x0 -> fmt=1, rt=8, imm_ext=0xFFFFFFFF, target=0x0.
REQ-036 0x3408FFFF -> imm_ext=0x0000FFFF; 0x3C081234 -> imm_ext=0x12340000; XLEN=64 run of 0x3C088000 -> 0xFFFFFFFF80000000.
REQ-037 j 0x08000010 at pc 0x00400000 -> fmt=2, target=0x00000040; beq 0x1000FFFF at pc 0x100 -> target=0x100.
REQ-038 Stream of 4 instructions with out_ready held 0 for 3 cycles -> state reaches TWO, in_ready=0; on release all 4 emerge in order with no gaps at full rate.
REQ-039 flush in TWO with in_valid=1 -> next cycle out_valid=0 and in_ready=1; no bundle from before or during the flush ever emerges.
REQ-040 opcode 0x3F -> fmt=3 emitted with valid handshake; rst asserted mid-stream -> out_valid=0 and all outputs 0 on the next cycle.
